fac_job_master: RTL

- Bus-master front end that drives the factorial system's slave bus (m_req/m_grant/m_wr/m_addr/m_dout/m_din/interrupt) on behalf of a simple command/response stream.
- Sits directly upstream of the factorial Top. For each accepted operand it:
  - writes operand, intrEn and opstart;
  - waits for the interrupt;
  - reads result_h and result_l;
  - pulses opclear (write 1, then write 0);
  - returns the 128-bit result.
- Replaces hand-sequenced bus traffic with a reusable hardware driver.

---
 rtl/fac_job_master.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fac_job_master.sv
// Bus-master driver for the factorial core: runs one operand through the
// register sequence (operand, intrEn, opstart, wait, read result, opclear).
module fac_job_master #(
  parameter logic [15:0] BASE_ADDR = 16'h7000,
  parameter int          TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_operand,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_result,
  output logic         rsp_err,
  output logic         m_req,
  input  logic         m_grant,
  output logic         m_wr,
  output logic [15:0]  m_addr,
  output logic [63:0]  m_dout,
  input  logic [63:0]  m_din,
  input  logic         interrupt,
  output logic         busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_OPD, S_WR_IEN, S_WR_STA, S_WAIT_INT, S_RD_HI, S_RD_HI_CAP,
    S_RD_LO, S_RD_LO_CAP, S_WR_CLR1, S_WR_CLR0, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [63:0]        opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
  logic               cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [127:0]       rsp_result_q, rsp_result_d;
  logic               rsp_err_q, rsp_err_d, m_req_q, m_req_d, m_wr_q, m_wr_d;
  logic [15:0]        m_addr_q, m_addr_d;
  logic [63:0]        m_dout_q, m_dout_d;
  logic               busy_q, busy_d;
  logic               granted;

  assign granted    = m_req_q && m_grant;
  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign m_req      = m_req_q;
  assign m_wr       = m_wr_q;
  assign m_addr     = m_addr_q;
  assign m_dout     = m_dout_q;
  assign busy       = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      m_req_q      <= 1'b0;
      m_wr_q       <= 1'b0;
      m_addr_q     <= '0;
      m_dout_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      m_req_q      <= m_req_d;
      m_wr_q       <= m_wr_d;
      m_addr_q     <= m_addr_d;
      m_dout_q     <= m_dout_d;
      busy_q       <= busy_d;
    end
    opd_q <= opd_d;
    hi_q  <= hi_d;
    lo_q  <= lo_d;
  end

  // Access states advance only on a granted cycle; capture states take m_din
  // one cycle after the granted read regardless of grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        opd_d   = cmd_operand;
        state_d = S_WR_OPD;
      end
      S_WR_OPD: if (granted) state_d = S_WR_IEN;
      S_WR_IEN: if (granted) state_d = S_WR_STA;
      S_WR_STA: if (granted) begin
        state_d = S_WAIT_INT;
        cnt_d   = '0;
      end
      S_WAIT_INT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (interrupt) begin
          state_d = S_RD_HI;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_WR_CLR1;
        end
      end
      S_RD_HI: if (granted) state_d = S_RD_HI_CAP;
      S_RD_HI_CAP: begin
        hi_d    = m_din;
        state_d = S_RD_LO;
      end
      S_RD_LO: if (granted) state_d = S_RD_LO_CAP;
      S_RD_LO_CAP: begin
        lo_d    = m_din;
        state_d = S_WR_CLR1;
      end
      S_WR_CLR1: if (granted) state_d = S_WR_CLR0;
      S_WR_CLR0: if (granted) state_d = S_RESP;
      S_RESP: if (rsp_ready) begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    m_req_d      = (state_d != S_IDLE) && (state_d != S_RESP);
    rsp_valid_d  = (state_d == S_RESP);
    rsp_err_d    = rsp_valid_d && err_d;
    rsp_result_d = (rsp_valid_d && !err_d) ? {hi_d, lo_d} : 128'd0;
    m_wr_d       = 1'b0;
    m_addr_d     = '0;
    m_dout_d     = '0;
    case (state_d)
      S_WR_OPD:   begin m_wr_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0020; m_dout_d = opd_d; end
      S_WR_IEN:   begin m_wr_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0018; m_dout_d = 64'd1; end
      S_WR_STA:   begin m_wr_d = 1'b1; m_addr_d = BASE_ADDR;            m_dout_d = 64'd1; end
      S_WAIT_INT: begin m_addr_d = BASE_ADDR; m_dout_d = 64'd1; end
      S_RD_HI, S_RD_HI_CAP: m_addr_d = BASE_ADDR + 16'h0028;
      S_RD_LO, S_RD_LO_CAP: m_addr_d = BASE_ADDR + 16'h0030;
      S_WR_CLR1:  begin m_wr_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0008; m_dout_d = 64'd1; end
      S_WR_CLR0:  begin m_wr_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0008; end
      default: ;
    endcase
  end

endmodule
